// File: rtl/cpu6502_pkg.sv
// Shared decode constants, FSM states and status-flag bit positions
// for the group-1 6502 subset core.
package cpu6502_pkg;

    typedef enum logic [2:0] {FETCH, ZP, PTR_LO, PTR_HI, ABS_LO, ABS_HI, EXEC} state_e;

    localparam logic [2:0] AAA_ORA = 3'd0, AAA_AND = 3'd1, AAA_EOR = 3'd2, AAA_ADC = 3'd3,
                           AAA_STA = 3'd4, AAA_LDA = 3'd5, AAA_CMP = 3'd6, AAA_SBC = 3'd7;

    localparam logic [2:0] BBB_IZX = 3'd0, BBB_ZP = 3'd1, BBB_IMM = 3'd2, BBB_ABS = 3'd3,
                           BBB_IZY = 3'd4, BBB_ZPX = 3'd5, BBB_ABSY = 3'd6, BBB_ABSX = 3'd7;

    localparam logic [7:0] OP_LDY_IMM = 8'hA0, OP_LDX_IMM = 8'hA2, OP_JMP_ABS = 8'h4C,
                           OP_CLC = 8'h18, OP_SEC = 8'h38, OP_NOP = 8'hEA, OP_STA_IMM = 8'h89;

    localparam int P_C = 0, P_Z = 1, P_U = 5, P_V = 6, P_N = 7;

    // State entered after the opcode byte; anything unrecognised runs as a 1-byte NOP.
    function automatic state_e after_fetch(input logic [7:0] op);
        if (op == OP_JMP_ABS) return ABS_LO;
        if (op == OP_NOP || op[1:0] != 2'b01) return EXEC;
        case (op[4:2])
            BBB_IMM:                     return EXEC;
            BBB_ABS, BBB_ABSX, BBB_ABSY: return ABS_LO;
            default:                     return ZP;
        endcase
    endfunction

endpackage

// File: rtl/cpu6502_if.sv
// Memory bus between the core (master) and the memory system (slave).
interface cpu6502_if;
    logic        i_ready;
    logic [7:0]  i_data;
    logic [15:0] o_addr;
    logic [7:0]  o_data;
    logic        o_wr;
    logic        o_sync;

    modport master (input i_ready, i_data, output o_addr, o_data, o_wr, o_sync);
    modport slave  (output i_ready, i_data, input o_addr, o_data, o_wr, o_sync);
endinterface

// File: rtl/cpu6502_alu.sv
// Combinational group-1 ALU: binary-only arithmetic, flags from the 8-bit result.
module cpu6502_alu
    import cpu6502_pkg::*;
(
    input  logic [2:0] op,
    input  logic [7:0] a,
    input  logic [7:0] m,
    input  logic       c_in,
    output logic [7:0] r,
    output logic       n,
    output logic       z,
    output logic       c,
    output logic       v
);
    logic [7:0] m2;
    logic       ci;
    logic [8:0] sum;

    always_comb begin
        // SBC and CMP share the adder through the complemented operand.
        m2  = (op == AAA_SBC || op == AAA_CMP) ? ~m : m;
        ci  = (op == AAA_CMP) ? 1'b1 : c_in;
        sum = {1'b0, a} + {1'b0, m2} + {8'h00, ci};
        case (op)
            AAA_ORA:          r = a | m;
            AAA_AND:          r = a & m;
            AAA_EOR:          r = a ^ m;
            AAA_STA, AAA_LDA: r = m;
            default:          r = sum[7:0];
        endcase
        n = r[7];
        z = (r == 8'h00);
        c = sum[8];
        v = ((a[7] ^ sum[7]) & (m2[7] ^ sum[7]));
    end
endmodule

// File: rtl/cpu6502_core.sv
// Multi-cycle 6502 subset: group-1 ALU ops in all eight address modes,
// plus LDX/LDY #imm, JMP abs, CLC/SEC; every other opcode is a 1-byte NOP.
module cpu6502_core
    import cpu6502_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [7:0]  ZP_PAGE  = 8'h00
) (
    input  logic       clock_25,
    input  logic       reset,
    cpu6502_if.master  bus,
    output logic [7:0] o_a,
    output logic [7:0] o_x,
    output logic [7:0] o_y,
    output logic [7:0] o_p
);
    state_e      state, state_nx;
    logic [15:0] pc, ea;
    logic [7:0]  ir, tmp, a, x, y, p;
    logic [2:0]  aaa, bbb;
    logic        grp1, imm, mem_op, store, ind;
    logic [7:0]  zp_idx, post_idx;
    logic [7:0]  alu_r;
    logic        alu_n, alu_z, alu_c, alu_v;

    assign aaa    = ir[7:5];
    assign bbb    = ir[4:2];
    assign grp1   = (ir[1:0] == 2'b01);
    assign imm    = (grp1 && bbb == BBB_IMM) || ir == OP_LDX_IMM || ir == OP_LDY_IMM;
    assign mem_op = grp1 && bbb != BBB_IMM;
    assign store  = grp1 && aaa == AAA_STA && ir != OP_STA_IMM;
    assign ind    = grp1 && (bbb == BBB_IZX || bbb == BBB_IZY);
    // Pre-index wraps inside the zero page; post-index is a full 16-bit add.
    assign zp_idx   = (grp1 && (bbb == BBB_ZPX || bbb == BBB_IZX)) ? x : 8'h00;
    assign post_idx = !grp1 ? 8'h00 :
                      (bbb == BBB_ABSX) ? x :
                      (bbb == BBB_ABSY || bbb == BBB_IZY) ? y : 8'h00;

    cpu6502_alu u_alu (
        .op   (grp1 ? aaa : AAA_LDA),
        .a    (a),
        .m    (bus.i_data),
        .c_in (p[P_C]),
        .r    (alu_r),
        .n    (alu_n),
        .z    (alu_z),
        .c    (alu_c),
        .v    (alu_v)
    );

    always_comb begin
        state_nx    = state;
        bus.o_addr  = pc;
        bus.o_sync  = 1'b0;
        bus.o_wr    = 1'b0;
        bus.o_data  = 8'h00;
        case (state)
            FETCH: begin
                bus.o_sync = 1'b1;
                state_nx   = after_fetch(bus.i_data);
            end
            ZP:     state_nx = ind ? PTR_LO : EXEC;
            PTR_LO: begin bus.o_addr = ea; state_nx = PTR_HI; end
            PTR_HI: begin bus.o_addr = {ZP_PAGE, ea[7:0] + 8'd1}; state_nx = EXEC; end
            ABS_LO: state_nx = ABS_HI;
            ABS_HI: state_nx = (ir == OP_JMP_ABS) ? FETCH : EXEC;
            EXEC: begin
                if (mem_op) bus.o_addr = ea;
                if (store) begin
                    bus.o_wr   = 1'b1;
                    bus.o_data = a;
                end
                state_nx = FETCH;
            end
            default: state_nx = FETCH;
        endcase
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            state <= FETCH;
            pc    <= RESET_PC;
            a     <= 8'h00;
            x     <= 8'h00;
            y     <= 8'h00;
            p     <= 8'h20;
            ir    <= 8'h00;
            tmp   <= 8'h00;
            ea    <= 16'h0000;
        end else if (bus.i_ready) begin
            state <= state_nx;
            case (state)
                FETCH: begin ir <= bus.i_data; pc <= pc + 16'd1; end
                ZP: begin
                    ea <= {ZP_PAGE, bus.i_data + zp_idx};
                    pc <= pc + 16'd1;
                end
                PTR_LO: tmp <= bus.i_data;
                PTR_HI: ea <= {bus.i_data, tmp} + {8'h00, post_idx};
                ABS_LO: begin tmp <= bus.i_data; pc <= pc + 16'd1; end
                ABS_HI: begin
                    if (ir == OP_JMP_ABS) pc <= {bus.i_data, tmp};
                    else begin
                        ea <= {bus.i_data, tmp} + {8'h00, post_idx};
                        pc <= pc + 16'd1;
                    end
                end
                EXEC: begin
                    if (imm) pc <= pc + 16'd1;
                    if (grp1) begin
                        case (aaa)
                            AAA_STA: ;
                            AAA_CMP: p[P_C] <= alu_c;
                            AAA_ADC, AAA_SBC: begin
                                a      <= alu_r;
                                p[P_C] <= alu_c;
                                p[P_V] <= alu_v;
                            end
                            default: a <= alu_r;
                        endcase
                        if (aaa != AAA_STA) begin p[P_N] <= alu_n; p[P_Z] <= alu_z; end
                    end else begin
                        case (ir)
                            OP_LDX_IMM: x <= alu_r;
                            OP_LDY_IMM: y <= alu_r;
                            OP_CLC:     p[P_C] <= 1'b0;
                            OP_SEC:     p[P_C] <= 1'b1;
                            default: ;
                        endcase
                        if (ir == OP_LDX_IMM || ir == OP_LDY_IMM) begin
                            p[P_N] <= alu_n;
                            p[P_Z] <= alu_z;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_a = a;
    assign o_x = x;
    assign o_y = y;
    assign o_p = p | (8'h01 << P_U);

endmodule

// File: tb/tb_cpu6502_core.sv
// Bench for cpu6502_core: an instruction-level model expands each opcode into its
// expected bus cycles, and every cycle of the DUT is compared against that list.
module tb_cpu6502_core;
    localparam logic [15:0] RPC = 16'h0200;
    localparam logic [7:0]  ZPG = 8'h00;

    logic       clock_25 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] o_a, o_x, o_y, o_p;

    cpu6502_if bus();

    cpu6502_core #(.RESET_PC(RPC), .ZP_PAGE(ZPG)) dut (
        .clock_25 (clock_25),
        .reset    (reset),
        .bus      (bus),
        .o_a      (o_a),
        .o_x      (o_x),
        .o_y      (o_y),
        .o_p      (o_p)
    );

    always #20 clock_25 = ~clock_25;

    logic [7:0] mem [0:65535];  // memory seen by the DUT
    logic [7:0] mm  [0:65535];  // model's private copy
    assign bus.i_data = mem[bus.o_addr];

    typedef struct {
        logic [15:0] addr;
        logic        sync, wr;
        logic [7:0]  data, a, x, y, p;
    } cyc_t;
    cyc_t q[$];

    logic [7:0]  ma, mx, my, mp;
    logic [15:0] mpc;
    int compared = 0, mismatched = 0, rc = 0, wrc = 0;
    logic [15:0] last_wa = 16'h0, last_addr = 16'h0;
    logic [7:0]  last_wd = 8'h0;

    function automatic void chk(input string nm, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic void put(input logic [15:0] ad, input logic [7:0] b);
        mem[ad] = b;
        mm[ad]  = b;
    endfunction

    function automatic void push(input logic [15:0] ad, input logic s, input logic w, input logic [7:0] d);
        cyc_t e;
        e.addr = ad; e.sync = s; e.wr = w; e.data = d;
        e.a = ma; e.x = mx; e.y = my; e.p = mp;
        q.push_back(e);
    endfunction

    function automatic void setnz(input logic [7:0] r);
        mp[7] = r[7];
        mp[1] = (r == 8'h00);
    endfunction

    function automatic int sgn(input logic [7:0] v);
        int s;
        s = int'(v);
        if (s > 127) s -= 256;
        return s;
    endfunction

    // Group-1 semantics written as plain signed/unsigned arithmetic.
    function automatic void alu_model(input logic [2:0] op, input logic [7:0] m);
        int s, sr, c;
        c = int'(mp[0]);
        case (op)
            3'd0: begin ma = ma | m; setnz(ma); end
            3'd1: begin ma = ma & m; setnz(ma); end
            3'd2: begin ma = ma ^ m; setnz(ma); end
            3'd3: begin
                s  = int'(ma) + int'(m) + c;
                sr = sgn(ma) + sgn(m) + c;
                mp[0] = (s > 255);
                mp[6] = (sr > 127 || sr < -128);
                ma = 8'(s); setnz(ma);
            end
            3'd5: begin ma = m; setnz(ma); end
            3'd6: begin
                mp[0] = (ma >= m);
                setnz(8'(int'(ma) - int'(m)));
            end
            3'd7: begin
                s  = int'(ma) - int'(m) - 1 + c;
                sr = sgn(ma) - sgn(m) - 1 + c;
                mp[0] = (s >= 0);
                mp[6] = (sr > 127 || sr < -128);
                ma = 8'(s); setnz(ma);
            end
            default: ;
        endcase
    endfunction

    function automatic void model_step();
        logic [7:0] op, lo, hi, zp, m;
        logic [15:0] ea;
        logic [2:0] aaa, bbb;
        bit mem_mode;
        ea = 16'h0;
        op = mm[mpc]; push(mpc, 1'b1, 1'b0, 8'h00); mpc++;
        aaa = op[7:5]; bbb = op[4:2];
        if (op[1:0] == 2'b01) begin
            mem_mode = 1;
            case (bbb)
                3'd2: begin
                    m = mm[mpc]; push(mpc, 1'b0, 1'b0, 8'h00); mpc++;
                    mem_mode = 0;
                    if (aaa != 3'd4) alu_model(aaa, m);
                end
                3'd1, 3'd5: begin
                    zp = mm[mpc]; push(mpc, 1'b0, 1'b0, 8'h00); mpc++;
                    zp = zp + ((bbb == 3'd5) ? mx : 8'h00);
                    ea = {ZPG, zp};
                end
                3'd0, 3'd4: begin
                    zp = mm[mpc]; push(mpc, 1'b0, 1'b0, 8'h00); mpc++;
                    zp = zp + ((bbb == 3'd0) ? mx : 8'h00);
                    lo = mm[{ZPG, zp}]; push({ZPG, zp}, 1'b0, 1'b0, 8'h00);
                    zp = zp + 8'd1;
                    hi = mm[{ZPG, zp}]; push({ZPG, zp}, 1'b0, 1'b0, 8'h00);
                    ea = {hi, lo} + {8'h00, (bbb == 3'd4) ? my : 8'h00};
                end
                default: begin
                    lo = mm[mpc]; push(mpc, 1'b0, 1'b0, 8'h00); mpc++;
                    hi = mm[mpc]; push(mpc, 1'b0, 1'b0, 8'h00); mpc++;
                    ea = {hi, lo} + {8'h00, (bbb == 3'd7) ? mx : (bbb == 3'd6) ? my : 8'h00};
                end
            endcase
            if (mem_mode) begin
                if (aaa == 3'd4) begin push(ea, 1'b0, 1'b1, ma); mm[ea] = ma; end
                else begin push(ea, 1'b0, 1'b0, 8'h00); alu_model(aaa, mm[ea]); end
            end
        end else begin
            case (op)
                8'hA2: begin push(mpc, 1'b0, 1'b0, 8'h00); mx = mm[mpc]; mpc++; setnz(mx); end
                8'hA0: begin push(mpc, 1'b0, 1'b0, 8'h00); my = mm[mpc]; mpc++; setnz(my); end
                8'h4C: begin
                    lo = mm[mpc]; push(mpc, 1'b0, 1'b0, 8'h00); mpc++;
                    hi = mm[mpc]; push(mpc, 1'b0, 1'b0, 8'h00);
                    mpc = {hi, lo};
                end
                8'h18: begin push(mpc, 1'b0, 1'b0, 8'h00); mp[0] = 1'b0; end
                8'h38: begin push(mpc, 1'b0, 1'b0, 8'h00); mp[0] = 1'b1; end
                default: push(mpc, 1'b0, 1'b0, 8'h00);
            endcase
        end
    endfunction

    // mode 0: ready, 1: random stalls, 2: forced stall. Entered and left at a negedge.
    task automatic cycle_step(input int mode);
        cyc_t e;
        logic rdy, w;
        logic [15:0] ad;
        logic [7:0] d;
        e = q[0];
        chk("addr", int'(bus.o_addr), int'(e.addr));
        chk("sync", int'(bus.o_sync), int'(e.sync));
        chk("wr",   int'(bus.o_wr),   int'(e.wr));
        chk("wdata", int'(bus.o_data), int'(e.data));
        if (e.sync) begin
            chk("reg_a", int'(o_a), int'(e.a));
            chk("reg_x", int'(o_x), int'(e.x));
            chk("reg_y", int'(o_y), int'(e.y));
            chk("reg_p", int'(o_p), int'(e.p));
        end
        ad = bus.o_addr; w = bus.o_wr; d = bus.o_data;
        rdy = (mode == 0) ? 1'b1 : (mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
        bus.i_ready = rdy;
        @(posedge clock_25);
        if (rdy) begin
            rc++;
            last_addr = ad;
            if (w) begin mem[ad] = d; wrc++; last_wa = ad; last_wd = d; end
            void'(q.pop_front());
        end
        @(negedge clock_25);
    endtask

    task automatic run_instrs(input int n, input int mode);
        int done = 0, guard = 0;
        while ((done < n || q.size() != 0) && guard < 20000) begin
            if (q.size() == 0) begin model_step(); done++; end
            cycle_step(mode);
            guard++;
        end
        if (guard >= 20000) chk("run_budget", guard, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.i_ready = 1'b0;
        @(posedge clock_25);
        @(negedge clock_25);
        reset = 1'b0;
        mpc = RPC; ma = 8'h00; mx = 8'h00; my = 8'h00; mp = 8'h20;
        q.delete();
    endtask

    initial begin
        #(40 * 90000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base, w0;
        bus.i_ready = 1'b0;
        for (int i = 0; i < 65536; i++) begin mem[i] = 8'h00; mm[i] = 8'h00; end
        @(negedge clock_25);

        // Reset state, then LDA #$7F; ADC #$01 overflows into the sign bit.
        do_reset();
        chk("rst_sync", int'(bus.o_sync), 1);
        chk("rst_addr", int'(bus.o_addr), int'(RPC));
        chk("rst_wr", int'(bus.o_wr), 0);
        chk("rst_data", int'(bus.o_data), 0);
        chk("rst_p", int'(o_p), 8'h20);
        put(16'h0200, 8'hA9); put(16'h0201, 8'h7F); put(16'h0202, 8'h69); put(16'h0203, 8'h01);
        base = rc;
        run_instrs(2, 0);
        chk("adc_cycles", rc - base, 4);
        chk("adc_a", int'(o_a), 8'h80);
        chk("adc_p", int'(o_p), 8'hE0);

        // STA $10,X then zero-page wrap on LDA $10,X with X=$F5.
        do_reset();
        put(16'h0200, 8'hA2); put(16'h0201, 8'h05); put(16'h0202, 8'hA9); put(16'h0203, 8'hAA);
        put(16'h0204, 8'h95); put(16'h0205, 8'h10); put(16'h0206, 8'hA2); put(16'h0207, 8'hF5);
        put(16'h0208, 8'hB5); put(16'h0209, 8'h10); put(16'h0005, 8'h77); put(16'h0105, 8'h99);
        w0 = wrc;
        run_instrs(3, 0);
        chk("stazx_wrcount", wrc - w0, 1);
        chk("stazx_addr", int'(last_wa), 16'h0015);
        chk("stazx_data", int'(last_wd), 8'hAA);
        run_instrs(2, 0);
        chk("zpwrap_addr", int'(last_addr), 16'h0005);
        chk("zpwrap_a", int'(o_a), 8'h77);

        // LDA ($FF),Y: pointer high byte wraps to $00 within the zero page.
        do_reset();
        put(16'h00FF, 8'h34); put(16'h0000, 8'h12); put(16'h0100, 8'h56); put(16'h1244, 8'hC3);
        put(16'h0200, 8'hA0); put(16'h0201, 8'h10); put(16'h0202, 8'hB1); put(16'h0203, 8'hFF);
        base = rc;
        run_instrs(2, 0);
        chk("izy_cycles", rc - base, 7);
        chk("izy_addr", int'(last_addr), 16'h1244);
        chk("izy_a", int'(o_a), 8'hC3);

        // SEC; LDA #5; CMP #6; SEC; SBC #5.
        do_reset();
        put(16'h0200, 8'h38); put(16'h0201, 8'hA9); put(16'h0202, 8'h05); put(16'h0203, 8'hC9);
        put(16'h0204, 8'h06); put(16'h0205, 8'h38); put(16'h0206, 8'hE9); put(16'h0207, 8'h05);
        run_instrs(3, 0);
        chk("cmp_a", int'(o_a), 8'h05);
        chk("cmp_p", int'(o_p), 8'hA0);
        run_instrs(2, 0);
        chk("sbc_a", int'(o_a), 8'h00);
        chk("sbc_p", int'(o_p), 8'h23);

        // Three stalled cycles in ABS_HI of STA $2000.
        do_reset();
        put(16'h0200, 8'hA9); put(16'h0201, 8'h5A); put(16'h0202, 8'h8D);
        put(16'h0203, 8'h00); put(16'h0204, 8'h20);
        run_instrs(1, 0);
        model_step();
        w0 = wrc;
        cycle_step(0); cycle_step(0);
        repeat (3) cycle_step(2);
        chk("stall_addr", int'(bus.o_addr), 16'h0204);
        cycle_step(0); cycle_step(0);
        chk("stall_wrcount", wrc - w0, 1);
        chk("stall_wa", int'(last_wa), 16'h2000);
        chk("stall_mem", int'(mem[16'h2000]), 8'h5A);

        // Reset lands in PTR_LO of LDA ($20,X), with i_ready low.
        do_reset();
        put(16'h0200, 8'hA9); put(16'h0201, 8'h33); put(16'h0202, 8'hA1); put(16'h0203, 8'h20);
        run_instrs(1, 0);
        model_step();
        cycle_step(0); cycle_step(0);
        chk("ptrlo_addr", int'(bus.o_addr), 16'h0020);
        do_reset();
        chk("midrst_sync", int'(bus.o_sync), 1);
        chk("midrst_addr", int'(bus.o_addr), int'(RPC));
        chk("midrst_wr", int'(bus.o_wr), 0);
        chk("midrst_a", int'(o_a), 0);

        // JMP $FFFE; LDA #$11 at the top of memory; PC wraps to $0000.
        do_reset();
        put(16'h0200, 8'h4C); put(16'h0201, 8'hFE); put(16'h0202, 8'hFF);
        put(16'hFFFE, 8'hA9); put(16'hFFFF, 8'h11); put(16'h0000, 8'hEA);
        base = rc;
        run_instrs(3, 0);
        chk("jmp_cycles", rc - base, 7);
        chk("wrap_addr", int'(bus.o_addr), 16'h0001);
        chk("wrap_a", int'(o_a), 8'h11);

        // Random memory image executed with random stalls.
        for (int i = 0; i < 65536; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            mem[i] = b; mm[i] = b;
        end
        do_reset();
        run_instrs(400, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/cpu6502_core.md
CPU6502_CORE -- requirements
Module: cpu6502_core

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: PC value loaded by reset.
REQ-002 SHALL have parameter ZP_PAGE, default 8'h00: high address byte used for all zero-page accesses.
REQ-003 SHALL have port clock_25, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port i_ready, input, 1 bit: memory ready; low stalls the current cycle.
REQ-006 SHALL have port i_data, input, 8 bits: read data, valid combinationally in the same cycle as o_addr.
REQ-007 SHALL have port o_addr, output, 16 bits: memory address.
REQ-008 SHALL have port o_data, output, 8 bits: write data.
REQ-009 SHALL have port o_wr, output, 1 bit: write strobe, one cycle per store.
REQ-010 SHALL have port o_sync, output, 1 bit: high in opcode-fetch cycles.
REQ-011 SHALL have ports o_a, o_x, o_y, o_p, output, 8 bits each: debug view of A, X, Y, P.

Function
REQ-012 SHALL fetch the opcode at PC in state FETCH, with o_sync=1 and PC+1.
REQ-013 SHALL execute group-1 opcodes aaa_bbb_01: aaa=ORA,AND,EOR,ADC,STA,LDA,CMP,SBC; bbb selects the address mode.
REQ-014 SHALL use these cycle counts, including fetch: #imm 2; zp 3; zp,X 3; abs 4; abs,X 4; abs,Y 4; (zp,X) 5; (zp),Y 5.
REQ-015 SHALL perform zero-page index adds (zp,X and pointer+X) modulo 256, with the high byte forced to ZP_PAGE.
REQ-016 SHALL fetch pointer high bytes from pointer+1 modulo 256 within ZP_PAGE.
REQ-017 SHALL perform abs,X, abs,Y and (zp),Y adds as full 16-bit adds in the high-byte cycle, with no page-cross penalty.
REQ-018 SHALL, in the final (EXEC) cycle of every mode except #imm, drive o_addr with the effective address; #imm reads at PC and increments PC.
REQ-019 SHALL, for STA in EXEC, assert o_wr=1 with o_data=A for exactly that cycle; o_wr SHALL be 0 in every other cycle.
REQ-020 SHALL treat STA #imm (8'h89) as a 2-cycle NOP that skips the operand byte.
REQ-021 SHALL also decode LDA-like LDX #imm (A2) and LDY #imm (A0) in 2 cycles; JMP abs (4C) in 3 cycles, with PC={hi,lo}; CLC (18) and SEC (38) in 2 cycles; NOP (EA) in 2 cycles.
REQ-022 SHALL execute every other opcode as a 2-cycle, 1-byte NOP.
REQ-023 SHALL compute ADC as {C,A} = A+M+C.
REQ-024 SHALL compute SBC as {C,A} = A+~M+C.
REQ-025 SHALL set V = (A^R)&(M'^R) bit 7 for ADC and SBC, where M' is the second adder operand.
REQ-026 SHALL compute CMP as A+~M+1, setting C (no-borrow), Z and N, with A unchanged.
REQ-027 SHALL update N and Z from the result for ORA, AND, EOR, LDA, LDX and LDY.
REQ-028 SHALL not support decimal mode; the D flag is ignored.
REQ-029 SHALL hold P bit layout NV1BDIZC, with bit 5 reading 1 always.
REQ-030 SHALL, when i_ready=0, hold all state, PC, registers, o_addr, o_data, o_wr and o_sync unchanged, and repeat the cycle.
REQ-031 SHALL wrap PC modulo 2^16 (FFFF+1 = 0000).
REQ-032 SHALL define state machine states FETCH, ZP, PTR_LO, PTR_HI, ABS_LO, ABS_HI and EXEC.
REQ-033 SHALL use these state sequences: #imm FETCH->EXEC; zp and zp,X FETCH->ZP->EXEC; abs and abs,X/Y FETCH->ABS_LO->ABS_HI->EXEC; (zp,X) and (zp),Y FETCH->ZP->PTR_LO->PTR_HI->EXEC; EXEC->FETCH.

Reset
REQ-034 SHALL, on a reset edge, set PC=RESET_PC, A=X=Y=0, P=8'h20, state=FETCH, regardless of the current state (a mid-instruction reset aborts the instruction).
REQ-035 SHALL, in the cycle after reset, drive o_wr=0, o_sync=1, o_addr=RESET_PC and o_data=0.
REQ-036 SHALL give reset priority over i_ready.

Structure
REQ-037 SHALL place the state enum, aaa op codes, special opcode constants and P bit indices in shared package cpu6502_pkg.
REQ-038 SHALL implement the ALU (8-bit op, carry in -> result, N Z C V) as combinational sub-module cpu6502_alu.
REQ-039 SHALL keep all sequencing in cpu6502_core.

Verification
REQ-040 SHALL test: LDA #$7F; ADC #$01 with C=0 -> A=80, N=1, V=1, Z=0, C=0, at 2 cycles each.
REQ-041 SHALL test: LDX #$05; LDA #$AA; STA $10,X -> single o_wr cycle, o_addr=0015, o_data=AA; and X=$F5, LDA $10,X reads 0005 (zero-page wrap).
REQ-042 SHALL test: ZP[FF]=34, ZP[00]=12, LDY #$10, LDA ($FF),Y -> EXEC o_addr=1244, 5 cycles.
REQ-043 SHALL test: SEC; LDA #$05; CMP #$06 -> C=0, N=1, Z=0, A=05; and SBC #$05 with C=1 from A=05 -> A=00, Z=1, C=1.
REQ-044 SHALL test: i_ready held low 3 cycles during ABS_HI of STA $2000 -> outputs frozen, exactly one o_wr at 2000.
REQ-045 SHALL test: reset asserted in PTR_LO -> next cycle o_sync=1, o_addr=RESET_PC, o_wr=0, A=0.
